// File: rtl/parking_gate_sequencer.sv
// Parking gate sequencer: arbitrates two entry lanes and one exit lane, drives the barrier, commits passes to the counter.
// Latency: grant and barrier_open appear 1 cycle after the IDLE decision; commit pulse CLOSE_CYCLES cycles after car_passed.
// Backpressure: one lane served at a time; other requests stay pending (level) until the FSM returns to IDLE.
module parking_gate_sequencer #(
    parameter int OPEN_HOUR    = 8,
    parameter int OPEN_TIMEOUT = 1000,
    parameter int CLOSE_CYCLES = 50,
    parameter int TIMER_W      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] hour,
    input  logic [1:0] ent_req,
    input  logic [1:0] ent_is_uni,
    input  logic       ext_req,
    input  logic       ext_is_uni,
    input  logic       car_passed,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic [1:0] ent_grant,
    output logic [1:0] ent_deny,
    output logic       ext_grant,
    output logic       barrier_open,
    output logic [1:0] active_lane,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited
);

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE, COMMIT} state_t;

    localparam logic [5:0]         OPEN_HOUR_L = 6'(OPEN_HOUR);
    localparam logic [TIMER_W-1:0] OPEN_LAST   = TIMER_W'(OPEN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] CLOSE_LAST  = TIMER_W'(CLOSE_CYCLES - 1);
    localparam logic [1:0]         LANE_EXT    = 2'd2;
    localparam logic [1:0]         LANE_NONE   = 2'd3;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               rr;
    logic [2:0]         armed;
    logic               passed;
    logic               car_uni;

    logic       ext_elig;
    logic [1:0] ent_elig;
    logic       pick_vld;
    logic [1:0] pick_lane;
    logic       pick_uni;
    logic       pick_admit;

    // Exit first since it frees space; entries round-robin with lane rr preferred.
    always_comb begin
        ext_elig   = ext_req & armed[2];
        ent_elig   = ent_req & armed[1:0];
        pick_vld   = 1'b0;
        pick_lane  = LANE_NONE;
        pick_uni   = 1'b0;
        pick_admit = 1'b0;
        if (hour >= OPEN_HOUR_L) begin
            if (ext_elig) begin
                pick_vld  = 1'b1;
                pick_lane = LANE_EXT;
                pick_uni  = ext_is_uni;
            end else if (ent_elig[rr]) begin
                pick_vld  = 1'b1;
                pick_lane = {1'b0, rr};
                pick_uni  = ent_is_uni[rr];
            end else if (ent_elig[~rr]) begin
                pick_vld  = 1'b1;
                pick_lane = {1'b0, ~rr};
                pick_uni  = ent_is_uni[~rr];
            end
        end
        if (pick_lane == LANE_EXT)
            pick_admit = 1'b1;
        else if (pick_uni)
            pick_admit = uni_is_vacated_space | is_vacated_space;
        else
            pick_admit = is_vacated_space;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            timer              <= '0;
            rr                 <= 1'b0;
            armed              <= 3'b111;
            passed             <= 1'b0;
            car_uni            <= 1'b0;
            ent_grant          <= 2'b00;
            ent_deny           <= 2'b00;
            ext_grant          <= 1'b0;
            barrier_open       <= 1'b0;
            active_lane        <= LANE_NONE;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
        end else begin
            ent_grant   <= 2'b00;
            ent_deny    <= 2'b00;
            ext_grant   <= 1'b0;
            car_entered <= 1'b0;
            car_exited  <= 1'b0;

            // A lane re-arms only after its request has been seen low.
            if (!ent_req[0]) armed[0] <= 1'b1;
            if (!ent_req[1]) armed[1] <= 1'b1;
            if (!ext_req)    armed[2] <= 1'b1;

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        armed[pick_lane] <= 1'b0;
                        if (pick_lane != LANE_EXT)
                            rr <= ~pick_lane[0];
                        if (pick_admit) begin
                            state        <= OPEN;
                            timer        <= '0;
                            active_lane  <= pick_lane;
                            car_uni      <= pick_uni;
                            barrier_open <= 1'b1;
                            if (pick_lane == LANE_EXT)
                                ext_grant <= 1'b1;
                            else
                                ent_grant[pick_lane[0]] <= 1'b1;
                        end else begin
                            ent_deny[pick_lane[0]] <= 1'b1;
                        end
                    end
                end
                OPEN: begin
                    if (car_passed || timer == OPEN_LAST) begin
                        state        <= CLOSE;
                        timer        <= '0;
                        barrier_open <= 1'b0;
                        passed       <= car_passed;
                        if (car_passed) begin
                            if (active_lane == LANE_EXT)
                                is_uni_car_exited <= car_uni;
                            else
                                is_uni_car_entered <= car_uni;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CLOSE: begin
                    if (timer == CLOSE_LAST) begin
                        timer <= '0;
                        if (passed) begin
                            state <= COMMIT;
                            if (active_lane == LANE_EXT)
                                car_exited <= 1'b1;
                            else
                                car_entered <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            active_lane <= LANE_NONE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state              <= IDLE;
                    timer              <= '0;
                    passed             <= 1'b0;
                    active_lane        <= LANE_NONE;
                    is_uni_car_entered <= 1'b0;
                    is_uni_car_exited  <= 1'b0;
                end
            endcase
        end
    end

endmodule
